// File: rtl/if_id_ctrl_pkg.sv
// Shared constants and types for the IF/ID controller: opcodes, special
// instruction encodings and the controller state type.
package if_id_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INST    = 32'h00000013;
    localparam logic [31:0] ECALL_INST  = 32'h00000073;
    localparam logic [31:0] EBREAK_INST = 32'h00100073;

    typedef enum logic [1:0] {
        ST_START,
        ST_RUN,
        ST_HALT
    } state_t;

    function automatic logic is_halt_inst(input logic [31:0] inst);
        return (inst == ECALL_INST) || (inst == EBREAK_INST);
    endfunction

endpackage

// File: rtl/if_id_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: flags an ID instruction that reads
// the destination of a load currently in EX.
module load_use_detect
    import if_id_ctrl_pkg::*;
(
    input  logic [31:0] id_inst,
    input  logic        id_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    output logic        hazard
);

    logic [6:0] opcode;
    logic       use_rs1;
    logic       use_rs2;
    logic       rs1_hit;
    logic       rs2_hit;

    always_comb begin
        opcode  = id_inst[6:0];
        use_rs1 = (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
        use_rs2 = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);
        rs1_hit = use_rs1 && (ex_rd == id_inst[19:15]);
        rs2_hit = use_rs2 && (ex_rd == id_inst[24:20]);
        hazard  = id_valid && ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/if_id_ctrl.sv
// Fetch-side controller: sequences reset vector load, load-use stalls,
// taken-branch squash and ECALL/EBREAK halt, and owns the IF/ID register.
module if_id_ctrl
    import if_id_ctrl_pkg::*;
#(
    parameter int unsigned           addr_width = 32,
    parameter int unsigned           word_width = 32,
    parameter logic [addr_width-1:0] RESET_VEC  = '0
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] if_inst,
    input  logic [addr_width-1:0] if_pc,
    input  logic                  ex_bch_taken,
    input  logic [addr_width-1:0] ex_bch_tgt,
    input  logic                  ex_mem_read,
    input  logic [4:0]            ex_rd,
    output logic                  pc_en,
    output logic                  stall_en,
    output logic                  jmp_bch_en,
    output logic [addr_width-1:0] jmp_bch_tgt,
    output logic [word_width-1:0] id_inst,
    output logic [addr_width-1:0] id_pc,
    output logic                  id_valid,
    output logic                  id_bubble,
    output logic                  halted,
    output logic [15:0]           stall_cnt
);

    state_t state;
    state_t state_nxt;
    logic   hazard;
    logic   load_nop;
    logic   advance;

    load_use_detect u_load_use_detect (
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hazard      (hazard)
    );

    // load_nop squashes IF/ID; advance captures the fetched instruction;
    // neither set means IF/ID holds (load-use stall).
    always_comb begin
        pc_en       = 1'b0;
        stall_en    = 1'b0;
        jmp_bch_en  = 1'b0;
        jmp_bch_tgt = '0;
        id_bubble   = 1'b0;
        load_nop    = 1'b0;
        advance     = 1'b0;
        state_nxt   = state;
        case (state)
            ST_START: begin
                pc_en       = 1'b1;
                jmp_bch_en  = 1'b1;
                jmp_bch_tgt = RESET_VEC;
                stall_en    = 1'b1;
                id_bubble   = 1'b1;
                load_nop    = 1'b1;
                state_nxt   = ST_RUN;
            end
            ST_RUN: begin
                if (ex_bch_taken) begin
                    pc_en       = 1'b1;
                    jmp_bch_en  = 1'b1;
                    jmp_bch_tgt = ex_bch_tgt;
                    stall_en    = 1'b1;
                    id_bubble   = 1'b1;
                    load_nop    = 1'b1;
                end else if (hazard) begin
                    id_bubble = 1'b1;
                end else if (id_valid && is_halt_inst(id_inst)) begin
                    stall_en  = 1'b1;
                    load_nop  = 1'b1;
                    state_nxt = ST_HALT;
                end else begin
                    pc_en   = 1'b1;
                    advance = 1'b1;
                end
            end
            ST_HALT: begin
                stall_en = 1'b1;
                load_nop = 1'b1;
            end
            default: begin
                state_nxt = ST_START;
            end
        endcase
    end

    assign halted = (state == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_START;
            id_inst   <= NOP_INST;
            id_pc     <= '0;
            id_valid  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_nop) begin
                id_inst  <= NOP_INST;
                id_valid <= 1'b0;
            end else if (advance) begin
                id_inst  <= if_inst;
                id_pc    <= if_pc;
                id_valid <= 1'b1;
            end
            if ((state == ST_RUN) && id_bubble && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_if_id_ctrl.sv
// Self-checking bench for if_id_ctrl: a small fetch-stage model feeds the DUT,
// expected controls and IF/ID contents are queued per cycle and compared.
module tb_if_id_ctrl;
    import if_id_ctrl_pkg::*;

    localparam logic [31:0] ADD_3_5_6  = 32'h006281B3;
    localparam logic [31:0] LUI_5      = 32'h123452B7;
    localparam logic [31:0] ADDI_1     = 32'h00100093;
    localparam logic [31:0] SW_6_5     = 32'h0062A023;
    localparam logic [31:0] ADD_10_7_0 = 32'h00038533;
    localparam logic [31:0] FILLER     = 32'h00000493;

    typedef struct {
        logic        pc_en;
        logic        stall_en;
        logic        jmp_en;
        logic [31:0] tgt;
        logic        bubble;
    } ctl_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [15:0] cnt;
        logic        halted;
        logic [31:0] fetch_pc;
    } reg_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        ex_bch_taken = 1'b0;
    logic [31:0] ex_bch_tgt = '0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        pc_en, stall_en, jmp_bch_en, id_valid, id_bubble, halted;
    logic [31:0] jmp_bch_tgt, id_inst, id_pc;
    logic [15:0] stall_cnt;

    logic [31:0] fetch_pc = 32'hDEAD0000;
    int          n_checks = 0;
    int          n_errors = 0;
    ctl_t        ctl_q[$];
    reg_t        reg_q[$];

    if_id_ctrl #(
        .addr_width (32),
        .word_width (32),
        .RESET_VEC  (32'h40)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .ex_bch_taken (ex_bch_taken),
        .ex_bch_tgt   (ex_bch_tgt),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .pc_en        (pc_en),
        .stall_en     (stall_en),
        .jmp_bch_en   (jmp_bch_en),
        .jmp_bch_tgt  (jmp_bch_tgt),
        .id_inst      (id_inst),
        .id_pc        (id_pc),
        .id_valid     (id_valid),
        .id_bubble    (id_bubble),
        .halted       (halted),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h40:  return ADD_3_5_6;
            32'h44:  return LUI_5;
            32'h48:  return ADDI_1;
            32'h4C:  return SW_6_5;
            32'h100: return ADD_10_7_0;
            32'h200: return ECALL_INST;
            default: return FILLER;
        endcase
    endfunction

    // Fetch stage: PC register plus instruction memory, NOP while stalled.
    always @(posedge clk)
        if (pc_en) fetch_pc <= jmp_bch_en ? jmp_bch_tgt : fetch_pc + 32'd4;
    assign if_pc   = fetch_pc;
    assign if_inst = stall_en ? NOP_INST : imem(fetch_pc);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    function automatic ctl_t mk_ctl(logic p, logic s, logic j, logic [31:0] t, logic b);
        ctl_t c;
        c.pc_en = p; c.stall_en = s; c.jmp_en = j; c.tgt = t; c.bubble = b;
        return c;
    endfunction

    function automatic reg_t mk_reg(logic v, logic [31:0] pc, logic [31:0] inst,
                                    logic [15:0] cnt, logic h, logic [31:0] fpc);
        reg_t r;
        r.valid = v; r.pc = pc; r.inst = inst; r.cnt = cnt; r.halted = h; r.fetch_pc = fpc;
        return r;
    endfunction

    // Called 1 time unit after a rising edge; returns 1 time unit after the next.
    task automatic step(input logic bt, input logic [31:0] btgt, input logic mr,
                        input logic [4:0] rd, input ctl_t c, input reg_t r);
        ctl_t ce;
        reg_t re;
        ex_bch_taken = bt; ex_bch_tgt = btgt; ex_mem_read = mr; ex_rd = rd;
        ctl_q.push_back(c);
        reg_q.push_back(r);
        @(negedge clk);
        ce = ctl_q.pop_front();
        check("pc_en", pc_en, ce.pc_en);
        check("stall_en", stall_en, ce.stall_en);
        check("jmp_bch_en", jmp_bch_en, ce.jmp_en);
        check("jmp_bch_tgt", jmp_bch_tgt, ce.tgt);
        check("id_bubble", id_bubble, ce.bubble);
        @(posedge clk);
        #1;
        re = reg_q.pop_front();
        check("id_valid", id_valid, re.valid);
        check("id_inst", id_inst, re.inst);
        if (re.valid) check("id_pc", id_pc, re.pc);
        check("stall_cnt", stall_cnt, re.cnt);
        check("halted", halted, re.halted);
        check("fetch_pc", fetch_pc, re.fetch_pc);
    endtask

    task automatic check_reset_regs();
        check("rst_id_valid", id_valid, 0);
        check("rst_id_inst", id_inst, NOP_INST);
        check("rst_id_pc", id_pc, 0);
        check("rst_halted", halted, 0);
        check("rst_stall_cnt", stall_cnt, 0);
    endtask

    initial begin
        ctl_t normal, stall, halt_c;
        normal = mk_ctl(1, 0, 0, 0, 0);
        stall  = mk_ctl(0, 0, 0, 0, 1);
        halt_c = mk_ctl(0, 1, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check_reset_regs();
        rst = 1'b0;

        step(0, 0, 0, 0, mk_ctl(1, 1, 1, 32'h40, 1), mk_reg(0, 0, NOP_INST, 0, 0, 32'h40));
        step(0, 0, 0, 0, normal, mk_reg(1, 32'h40, ADD_3_5_6, 0, 0, 32'h44));
        step(0, 0, 1, 5, stall,  mk_reg(1, 32'h40, ADD_3_5_6, 1, 0, 32'h44));
        step(0, 0, 0, 5, normal, mk_reg(1, 32'h44, LUI_5, 1, 0, 32'h48));
        step(0, 0, 1, 8, normal, mk_reg(1, 32'h48, ADDI_1, 1, 0, 32'h4C));
        step(0, 0, 1, 0, normal, mk_reg(1, 32'h4C, SW_6_5, 1, 0, 32'h50));
        step(0, 0, 1, 6, stall,  mk_reg(1, 32'h4C, SW_6_5, 2, 0, 32'h50));
        step(1, 32'h100, 0, 0, mk_ctl(1, 1, 1, 32'h100, 1), mk_reg(0, 0, NOP_INST, 3, 0, 32'h100));
        step(0, 0, 0, 0, normal, mk_reg(1, 32'h100, ADD_10_7_0, 3, 0, 32'h104));
        step(1, 32'h200, 1, 7, mk_ctl(1, 1, 1, 32'h200, 1), mk_reg(0, 0, NOP_INST, 4, 0, 32'h200));
        step(0, 0, 0, 0, normal, mk_reg(1, 32'h200, ECALL_INST, 4, 0, 32'h204));
        step(0, 0, 0, 0, halt_c, mk_reg(0, 0, NOP_INST, 4, 1, 32'h204));
        step(1, 32'h300, 0, 0, halt_c, mk_reg(0, 0, NOP_INST, 4, 1, 32'h204));
        step(1, 32'h300, 1, 5, halt_c, mk_reg(0, 0, NOP_INST, 4, 1, 32'h204));

        ex_bch_taken = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_regs();
        rst = 1'b0;
        step(0, 0, 0, 0, mk_ctl(1, 1, 1, 32'h40, 1), mk_reg(0, 0, NOP_INST, 0, 0, 32'h40));
        step(0, 0, 0, 0, normal, mk_reg(1, 32'h40, ADD_3_5_6, 0, 0, 32'h44));

        // Hold a load-use hazard long enough to saturate the bubble counter.
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        repeat (65540) @(posedge clk);
        #1;
        check("sat_stall_cnt", stall_cnt, 32'h0000FFFF);
        check("sat_id_pc", id_pc, 32'h40);
        check("sat_pc_en", pc_en, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
